// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: load-use
// stalls, branch/jump redirects, memory-busy freeze and lost-cycle counters.
module pipeline_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic              id_isRtype,
  input  logic              id_isItype,
  input  logic              id_isLw,
  input  logic              id_isStype,
  input  logic              id_isbranch,
  input  logic              id_isjump,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_taken,
  input  logic              mem_busy,
  output logic              freeze,
  output logic              stall_if,
  output logic              stall_id,
  output logic              bubble_ex,
  output logic              flush_if,
  output logic [1:0]        pc_sel,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  // MEM-stage producers are always forwarded, so only EX is tracked.
  logic              ex_v_q, ex_v_d;
  logic              ex_ld_q, ex_ld_d;
  logic              ex_br_q, ex_br_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic use1, use2, hit1, hit2;
  logic load_use, br_taken, jump;
  logic inc_stall, inc_flush;

  assign use1 = id_isRtype | id_isItype | id_isLw
              | id_isStype | id_isbranch;
  assign use2 = id_isRtype | id_isStype | id_isbranch;
  assign hit1 = use1 && (id_rs1 == ex_rd_q);
  assign hit2 = use2 && (id_rs2 == ex_rd_q);

  assign load_use = id_valid && ex_v_q && ex_ld_q
                 && (ex_rd_q != '0) && (hit1 || hit2);
  assign br_taken = ex_v_q && ex_br_q && ex_taken;
  assign jump     = id_valid && id_isjump;

  always_comb begin
    freeze    = 1'b0;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    bubble_ex = 1'b0;
    flush_if  = 1'b0;
    pc_sel    = PC_SEQ;
    inc_stall = 1'b0;
    inc_flush = 1'b0;
    if (mem_busy) begin
      freeze   = 1'b1;
      stall_if = 1'b1;
      stall_id = 1'b1;
    end else if (br_taken) begin
      pc_sel    = PC_BR;
      flush_if  = 1'b1;
      bubble_ex = 1'b1;
      inc_flush = 1'b1;
    end else if (load_use) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      bubble_ex = 1'b1;
      inc_stall = 1'b1;
    end else if (jump) begin
      pc_sel   = PC_JMP;
      flush_if = 1'b1;
    end
  end

  always_comb begin
    ex_v_d  = bubble_ex ? 1'b0 : id_valid;
    ex_ld_d = bubble_ex ? 1'b0 : id_isLw;
    ex_br_d = bubble_ex ? 1'b0 : id_isbranch;
    ex_rd_d = bubble_ex ? '0 : id_rd;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (inc_stall && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (inc_flush && (flush_cnt_q != {CNT_W{1'b1}}))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_v_q      <= 1'b0;
      ex_ld_q     <= 1'b0;
      ex_br_q     <= 1'b0;
      ex_rd_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (!freeze) begin
      ex_v_q      <= ex_v_d;
      ex_ld_q     <= ex_ld_d;
      ex_br_q     <= ex_br_d;
      ex_rd_q     <= ex_rd_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
